// File: rtl/elelock_ctrl.sv
// Electronic lock sequencer: press-qualified multi-digit BCD entry, code check, timed lockout.
// Define ELELOCK_PROG_EN to make the secret a register that can be reprogrammed while OPEN.
module elelock_ctrl #(
    parameter int                  DIGITS      = 4,
    parameter logic [DIGITS*4-1:0] SECRET      = 16'h1234,
    parameter int                  MAX_FAIL    = 3,
    parameter int                  LOCKOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] tenkey,
    input  logic       close,
    output logic       lock,
    output logic       alarm,
    output logic [2:0] digit_cnt
);

    localparam int         CW       = DIGITS * 4;
    localparam int         FW       = $clog2(MAX_FAIL + 1);
    localparam int         TW       = $clog2(LOCKOUT_CYC + 1);
    localparam logic [2:0] LAST_CNT = 3'(DIGITS - 1);

    typedef enum logic [1:0] {LOCKED, CHECK, OPEN, LOCKOUT} state_t;

    state_t        state;
    logic [9:0]    hist;
    logic [CW-1:0] entry;
    logic [CW-1:0] entry_next;
    logic [CW-1:0] secret;
    logic [FW-1:0] fails;
    logic [TW-1:0] timer;
    logic          press;
    logic [3:0]    digit;

    always_comb begin
        digit = '0;
        for (int i = 0; i < 10; i++) begin
            if (tenkey[i]) digit = 4'(i);
        end
    end

    // A press needs a clean one-hot pattern after an all-released sample.
    assign press = (hist == '0) && $onehot(tenkey);

    always_comb begin
        entry_next      = entry << 4;
        entry_next[3:0] = digit;
    end

`ifndef ELELOCK_PROG_EN
    assign secret = SECRET;
`endif

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LOCKED;
            lock      <= 1'b1;
            alarm     <= 1'b0;
            digit_cnt <= '0;
            fails     <= '0;
            entry     <= '0;
            hist      <= '0;
            timer     <= '0;
`ifdef ELELOCK_PROG_EN
            secret    <= SECRET;
`endif
        end else begin
            hist <= tenkey;
            case (state)
                LOCKED: begin
                    if (close) begin
                        entry     <= '0;
                        digit_cnt <= '0;
                    end else if (press) begin
                        entry     <= entry_next;
                        digit_cnt <= digit_cnt + 3'd1;
                        if (digit_cnt == LAST_CNT) state <= CHECK;
                    end
                end
                CHECK: begin
                    entry     <= '0;
                    digit_cnt <= '0;
                    if (entry == secret) begin
                        state <= OPEN;
                        lock  <= 1'b0;
                        fails <= '0;
                    end else if (fails == FW'(MAX_FAIL - 1)) begin
                        state <= LOCKOUT;
                        alarm <= 1'b1;
                        fails <= FW'(MAX_FAIL);
                        timer <= TW'(LOCKOUT_CYC);
                    end else begin
                        state <= LOCKED;
                        fails <= fails + FW'(1);
                    end
                end
                OPEN: begin
                    if (close) begin
                        state     <= LOCKED;
                        lock      <= 1'b1;
                        entry     <= '0;
                        digit_cnt <= '0;
                    end
`ifdef ELELOCK_PROG_EN
                    else if (press) begin
                        if (digit_cnt == LAST_CNT) begin
                            secret    <= entry_next;
                            entry     <= '0;
                            digit_cnt <= '0;
                        end else begin
                            entry     <= entry_next;
                            digit_cnt <= digit_cnt + 3'd1;
                        end
                    end
`endif
                end
                LOCKOUT: begin
                    timer <= timer - TW'(1);
                    if (timer == TW'(1)) begin
                        state <= LOCKED;
                        alarm <= 1'b0;
                        fails <= '0;
                    end
                end
                default: state <= LOCKED;
            endcase
        end
    end

endmodule

// File: tb/tb_elelock_ctrl.sv
// Self-checking bench for elelock_ctrl: directed test-plan sequences plus randomized
// keypad traffic, both compared every cycle against a digit-queue reference model.
module tb_elelock_ctrl;

    localparam int          DIGITS      = 4;
    localparam int          MAX_FAIL    = 3;
    localparam int          LOCKOUT_CYC = 8;
    localparam logic [15:0] SECRET      = 16'h1234;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] tenkey;
    logic       close;
    logic       lock;
    logic       alarm;
    logic [2:0] digit_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int alarm_hi    = 0;

    // Reference model: entered digits as a queue, secret as a number.
    logic [9:0] m_prev;
    int         m_entry[$];
    int         m_secret;
    bit         m_open;
    bit         m_checking;
    int         m_lockleft;
    int         m_fails;

    elelock_ctrl #(
        .DIGITS     (DIGITS),
        .SECRET     (SECRET),
        .MAX_FAIL   (MAX_FAIL),
        .LOCKOUT_CYC(LOCKOUT_CYC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tenkey   (tenkey),
        .close    (close),
        .lock     (lock),
        .alarm    (alarm),
        .digit_cnt(digit_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [9:0] onehot_key(input int d);
        logic [9:0] v;
        v    = '0;
        v[d] = 1'b1;
        return v;
    endfunction

    function automatic int code_of(input int q[$]);
        int v = 0;
        foreach (q[i]) v = v * 16 + q[i];
        return v;
    endfunction

    function automatic void model_reset();
        m_prev     = '0;
        m_entry.delete();
        m_secret   = int'(SECRET);
        m_open     = 1'b0;
        m_checking = 1'b0;
        m_lockleft = 0;
        m_fails    = 0;
    endfunction

    function automatic void model_step(input logic [9:0] k, input logic c);
        bit pr;
        int d;
        pr = (m_prev == '0) && ($countones(k) == 1);
        d  = 0;
        for (int i = 0; i < 10; i++) if (k[i]) d = i;
        m_prev = k;
        if (m_lockleft > 0) begin
            m_lockleft--;
            if (m_lockleft == 0) m_fails = 0;
        end else if (m_checking) begin
            if (code_of(m_entry) == m_secret) begin
                m_open  = 1'b1;
                m_fails = 0;
            end else begin
                m_fails++;
                if (m_fails >= MAX_FAIL) m_lockleft = LOCKOUT_CYC;
            end
            m_entry.delete();
            m_checking = 1'b0;
        end else if (m_open) begin
            if (c) begin
                m_open = 1'b0;
                m_entry.delete();
            end
`ifdef ELELOCK_PROG_EN
            else if (pr) begin
                m_entry.push_back(d);
                if (m_entry.size() == DIGITS) begin
                    m_secret = code_of(m_entry);
                    m_entry.delete();
                end
            end
`endif
        end else begin
            if (c) m_entry.delete();
            else if (pr) begin
                m_entry.push_back(d);
                if (m_entry.size() == DIGITS) m_checking = 1'b1;
            end
        end
    endfunction

    // Next digit of the current secret, used to bias random traffic towards valid codes.
    function automatic int hint_digit();
        int pos;
        pos = m_entry.size();
        if (pos >= DIGITS) return 0;
        return (m_secret >> (4 * (DIGITS - 1 - pos))) & 15;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".lock"},  32'(lock),      32'(!m_open));
        check({tag, ".alarm"}, 32'(alarm),     32'(m_lockleft > 0));
        check({tag, ".cnt"},   32'(digit_cnt), 32'(m_entry.size()));
    endtask

    task automatic cycle(input logic [9:0] k, input logic c, input string tag);
        tenkey = k;
        close  = c;
        @(posedge clk);
        model_step(k, c);
        #1;
        if (alarm === 1'b1) alarm_hi++;
        check_model(tag);
    endtask

    task automatic key(input int d, input string tag);
        repeat (2) cycle(onehot_key(d), 1'b0, tag);
        repeat (2) cycle('0, 1'b0, tag);
    endtask

    task automatic enter(input int code, input string tag);
        for (int i = DIGITS - 1; i >= 0; i--) key((code >> (4 * i)) & 15, tag);
    endtask

    task automatic apply_reset(input string tag);
        reset  = 1'b1;
        tenkey = '0;
        close  = 1'b0;
        #1;
        model_reset();
        check_model(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Reset mid-entry, then the reset secret opens the lock.
        apply_reset("por");
        key(1, "t1_entry");
        key(2, "t1_entry");
        check("t1_cnt_before_rst", 32'(digit_cnt), 32'd2);
        apply_reset("t1_mid_rst");
        check("t1_rst_lock",  32'(lock),      32'd1);
        check("t1_rst_alarm", 32'(alarm),     32'd0);
        check("t1_rst_cnt",   32'(digit_cnt), 32'd0);
        enter(16'h1234, "t1_code");
        check("t1_open", 32'(lock), 32'd0);
        cycle('0, 1'b1, "t1_close");
        check("t1_relock", 32'(lock), 32'd1);

        // Held-key entry timing: count 1..4, then clear and open one edge later.
        for (int i = 1; i <= 4; i++) begin
            cycle(onehot_key(i), 1'b0, "t2_press");
            check("t2_cnt", 32'(digit_cnt), 32'(i));
            cycle(onehot_key(i), 1'b0, "t2_hold");
            if (i == 4) begin
                check("t2_open",    32'(lock),      32'd0);
                check("t2_cnt_clr", 32'(digit_cnt), 32'd0);
            end
            repeat (2) cycle('0, 1'b0, "t2_rel");
        end
        cycle('0, 1'b1, "t2_close");
        check("t2_relock", 32'(lock), 32'd1);

        // Three wrong codes: lockout for exactly LOCKOUT_CYC cycles, presses ignored.
        alarm_hi = 0;
        repeat (3) enter(16'h1235, "t3_wrong");
        for (int j = 0; j < 6; j++) begin
            cycle((j % 2 == 0) ? onehot_key(7) : 10'b0, 1'b0, "t3_lockout_press");
            check("t3_cnt_held", 32'(digit_cnt), 32'd0);
        end
        repeat (4) cycle('0, 1'b0, "t3_idle");
        check("t3_alarm_len", 32'(alarm_hi), 32'(LOCKOUT_CYC));
        enter(16'h1234, "t3_code");
        check("t3_open", 32'(lock), 32'd0);
        cycle('0, 1'b1, "t3_close");

        // Press qualification: held, multi-bit, release-then-press.
        repeat (10) cycle(10'b0000000010, 1'b0, "t4_hold");
        check("t4_held_once", 32'(digit_cnt), 32'd1);
        cycle(10'b0000000011, 1'b0, "t4_multi");
        check("t4_multi_ignored", 32'(digit_cnt), 32'd1);
        cycle(10'b0000000000, 1'b0, "t4_release");
        cycle(10'b0000000100, 1'b0, "t4_press2");
        check("t4_second", 32'(digit_cnt), 32'd2);
        cycle('0, 1'b1, "t4_clear");

        // Close clears entry; a correct code clears the fail count.
        key(1, "t5_entry");
        key(2, "t5_entry");
        cycle('0, 1'b1, "t5_close");
        check("t5_cnt_clr", 32'(digit_cnt), 32'd0);
        alarm_hi = 0;
        enter(16'h9999, "t5_wrong");
        enter(16'h1234, "t5_code");
        check("t5_open", 32'(lock), 32'd0);
        cycle('0, 1'b1, "t5_close2");
        enter(16'h9999, "t5_wrong2");
        enter(16'h9999, "t5_wrong3");
        check("t5_no_alarm", 32'(alarm_hi), 32'd0);
        enter(16'h1234, "t5_code2");
        check("t5_open2", 32'(lock), 32'd0);

`ifdef ELELOCK_PROG_EN
        // Reprogram to 5678 while open; old code then fails, new code opens.
        enter(16'h5678, "t6_prog");
        check("t6_still_open", 32'(lock), 32'd0);
        cycle('0, 1'b1, "t6_close");
        enter(16'h1234, "t6_old");
        check("t6_old_fails", 32'(lock), 32'd1);
        enter(16'h5678, "t6_new");
        check("t6_new_opens", 32'(lock), 32'd0);
`endif
        cycle('0, 1'b1, "t5_final_close");

        // Random keypad traffic biased towards the current secret.
        for (int n = 0; n < 600; n++) begin
            logic [9:0] k;
            logic       c;
            int         r;
            if (n == 300) apply_reset("rand_rst");
            r = int'($urandom_range(0, 99));
            if (r < 40)      k = '0;
            else if (r < 70) k = onehot_key(hint_digit());
            else if (r < 90) k = onehot_key(int'($urandom_range(0, 9)));
            else             k = 10'($urandom_range(0, 1023));
            c = ($urandom_range(0, 99) < 4);
            cycle(k, c, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/elelock_ctrl.md
# elelock_ctrl

Sequencing controller for the electronic lock. It takes raw one-hot tenkey presses and assembles a multi-digit BCD code, then checks it against the secret and drives `lock`. Repeated failures put it in a timed lockout with `alarm` raised. It replaces the single-digit check with a press-qualified, stateful entry sequence.

## Interface
- `DIGITS`, 4: code length in BCD digits, 1..7.
- `SECRET`, 16'h1234: reset secret, `DIGITS*4` bits, digit 0 in the most significant nibble (first digit entered).
- `MAX_FAIL`, 3: consecutive mismatches that trigger lockout, ≥1.
- `LOCKOUT_CYC`, 1000: lockout duration in clk cycles, ≥1.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `tenkey`  input  10  key switches; bit i pressed = digit i.
- `close`  input  1  level; relock request and entry clear.
- `lock`  output  1  1 = locked.
- `alarm`  output  1  1 = lockout active.
- `digit_cnt`  output  3  digits collected in the current entry.

## Operation
- Reset values: `lock`=1, `alarm`=0, `digit_cnt`=0, state LOCKED, fail count 0, entry buffer 0, `tenkey` history register 0.
- Press event: at an edge, `tenkey` is exactly one-hot and the history register (the previous edge's `tenkey` sample) is all zero. The history register updates every edge in every state.
  - Multi-bit or held patterns never generate a press.
  - A key must go back to all-zero before it can generate another press.
- LOCKED
  - Each press shifts the digit into the buffer (buffer <= {buffer, digit}) and increments `digit_cnt`.
  - The `DIGITS`-th press moves the state to CHECK.
  - `close`=1 clears the buffer and `digit_cnt` and takes priority over a press in the same cycle.
- CHECK (exactly one cycle; presses and `close` are ignored)
  - On match: go to OPEN, `lock`<=0, fail count <= 0.
  - On mismatch: fail count increments. If it reaches `MAX_FAIL`, go to LOCKOUT, `alarm`<=1, timer <= `LOCKOUT_CYC`. Otherwise go to LOCKED.
  - In both cases the buffer and `digit_cnt` clear.
- OPEN
  - `lock`=0.
  - `close`=1 moves to LOCKED with `lock`<=1 and clears the buffer and `digit_cnt`.
  - Presses are handled as described under Configuration.
- LOCKOUT
  - Presses and `close` are ignored.
  - The timer decrements each edge. On the edge where it goes from 1 to 0, the state moves to LOCKED, `alarm`<=0 and fail count <= 0.
- `digit_cnt` never exceeds `DIGITS`. The fail count saturates at `MAX_FAIL`.

## Timing
- A press is acted on at the edge where it is detected: `digit_cnt` updates after that edge.
- Final digit accepted at edge E:
  - state is CHECK after E;
  - `lock` or `alarm` changes after edge E+1.
- `alarm` stays high for exactly `LOCKOUT_CYC` cycles.
- `close` in OPEN gives `lock`=1 after the next edge.
- Reset asserted in any state, including mid-entry, CHECK or LOCKOUT, immediately forces all reset values. No pending action survives.
- All outputs are registered.

## Configuration
- `ELELOCK_PROG_EN` defined:
  - The secret is held in a register loaded with `SECRET` at reset.
  - In OPEN, presses fill the buffer and `digit_cnt` the same way as in LOCKED.
  - On the `DIGITS`-th press, the secret register is loaded with the new code at that edge, and the buffer and `digit_cnt` clear. The state stays OPEN.
  - `close` discards a partial entry.
- Undefined: the secret is the constant `SECRET`, and presses in OPEN are ignored with `digit_cnt` held at 0.

## Test plan
- Reset mid-entry after digits 1,2 → `lock`=1, `alarm`=0, `digit_cnt`=0 immediately. Keys 1,2,3,4 afterwards open the lock.
- Keys 1,2,3,4, each held 2 cycles then released 2 cycles → `digit_cnt` goes 1..4, then 0; `lock`=0 two edges after the 4th press. `close`=1 → `lock`=1 one edge later.
- `MAX_FAIL`=3, `LOCKOUT_CYC`=8; enter 1,2,3,5 three times → `alarm`=1 for exactly 8 cycles. Presses during lockout leave `digit_cnt` at 0. Afterwards 1,2,3,4 gives `lock`=0.
- Hold `tenkey`=10'b0000000010 for 10 cycles → `digit_cnt`=1. Apply 10'b0000000011 → no change. Apply 10'b0000000000 then 10'b0000000100 → `digit_cnt`=2.
- Keys 1,2, then `close`=1 → `digit_cnt`=0. Wrong code 9,9,9,9 then the correct code → fail count clears and `alarm` never asserts.
- With `ELELOCK_PROG_EN`: open with 1234, enter 5,6,7,8, `close` → 1,2,3,4 fails. Then 5,6,7,8 gives `lock`=0.
